mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Multicycle control unit for the MIPS CPU core (`Main`). It sequences each instruction through the IF/ID/EXE/MEM/WB states from the latched opcode and the ALU zero flag. It drives all datapath strobes and mux selects: PC write, IR write, register file, ALU, data memory and next-PC source. It sits beside the datapath and is clocked by the same `CLK`.

Parameters:
OPW, 6, opcode width
HALT_OP, 6'b111111, opcode that stops the core

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous reset, active-low (0 = reset, sampled on rising CLK)
op  in  OPW  opcode from IR[31:26], valid from ID onward
zero  in  1  ALU zero flag, valid in EXE
mem_ready  in  1  data-memory ready (used only with MEM_WAIT_EN)
PCWre  out  1  PC write enable
IRWre  out  1  IR write enable
InsMemRW  out  1  instruction memory read
ALUSrcA  out  1  1 = shamt/sa
ALUSrcB  out  1  1 = extended immediate
ALUOp  out  3  000 add, 001 sub, 010 slt, 011 or, 100 and
ExtSel  out  1  1 = sign-extend, 0 = zero-extend
RegDst  out  2  00 = $31, 01 = rt, 10 = rd
RegWre  out  1  register file write enable
WrRegDSrc  out  1  0 = PC+4 (jal), 1 = DB
DBDataSrc  out  1  0 = ALU result, 1 = memory data
mRD  out  1  data-memory read
mWR  out  1  data-memory write
PCSrc  out  2  00 = PC+4, 01 = branch, 10 = jr, 11 = j/jal
state  out  3  current state, for debug
halted  out  1  core stopped

Behaviour:
- State encoding: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111. `state` is registered; all other outputs decode combinationally from `state` and `op`.
- Reset (RST=0 at a rising edge): state=IF. Mid-instruction reset aborts the instruction with no further strobes.
- Strobes during reset: PCWre=0 and RegWre=0 while RST=0.
- IF: IRWre=1, InsMemRW=1; next state ID.
- ID:
  - j/jal/jr: PCWre=1, PCSrc=11/11/10; jal also RegWre=1, RegDst=00, WrRegDSrc=0; next IF.
  - HALT_OP: next HALT.
  - All other opcodes: next EXE.
- EXE: ALU selects are driven per opcode.
  - beq/bne: ALUOp=001; PCWre=1; PCSrc=01 if (beq & zero) or (bne & ~zero), else 00; next IF.
  - sw/lw: ALUOp=000, ALUSrcB=1, ExtSel=1; next MEM.
  - Arithmetic/logic: next WB.
- MEM:
  - sw: mWR=1, PCWre=1, PCSrc=00; next IF.
  - lw: mRD=1; next WB.
- WB: RegWre=1, PCWre=1, PCSrc=00. R-type uses RegDst=10; immediate ops and lw use 01. DBDataSrc=1 only for lw. Next IF.
- Opcode table:
  - add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, sll 011000, slt 100110
  - sw 110000, lw 110001, beq 110100, bne 110101, j 111000, jr 111001, jal 111010
- ExtSel for immediate ops: andi and ori zero-extend; addiu, lw, sw, beq and bne sign-extend.
- Unknown opcode: treated as NOP via ID→EXE→WB with RegWre=0.
- HALT: all enables 0, halted=1, and the state holds until reset.
- Latency in cycles: j/jal/jr 2; beq/bne 3; R/I-arith and sw 4; lw 5.
- PCWre is asserted exactly once per instruction, in its final state.
- mRD, mWR and RegWre are never asserted simultaneously.

Optional Feature:
MEM_WAIT_EN:
- Defined: MEM holds while mem_ready=0. mRD/mWR stay asserted and PCWre stays 0 until the first cycle with mem_ready=1. That cycle completes as specified above.
- Undefined: mem_ready is ignored and MEM always lasts one cycle.

Test Plan:
- RST=0 for 2 edges, then RST=1 with op=000000 → state sequence IF,ID,EXE,WB,IF. RegWre=1 and RegDst=10 only in WB; PCWre=1 only in WB.
- op=110001 (lw) → 5-cycle sequence IF,ID,EXE,MEM,WB. mRD=1 in MEM; DBDataSrc=1 and RegWre=1 in WB.
- op=110100 (beq): zero=1 → PCSrc=01 in EXE; zero=0 → PCSrc=00. Both return to IF after 3 cycles.
- op=111010 (jal) → 2 cycles. In ID: PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0.
- op=111111 → HALT reached after ID, halted=1 and PCWre=0 for 20 cycles. RST=0 then returns state=IF.
- MEM_WAIT_EN with op=110000 (sw) and mem_ready=0 for 3 cycles → MEM held 4 cycles with mWR=1. PCWre=1 only in the mem_ready=1 cycle. Also RST=0 in MEM → state=IF next edge with no PCWre.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle MIPS control unit (IF/ID/EXE/MEM/WB/HALT)
//
// Sequences each instruction through the multicycle states from the latched
// opcode and the ALU zero flag, and decodes every datapath strobe and mux
// select combinationally from the registered state and the opcode.
//
// Optional feature macro: MEM_WAIT_EN
//   defined   - MEM holds while mem_ready=0 (mRD/mWR stay up, PCWre stays 0)
//   undefined - mem_ready is ignored, MEM always lasts one cycle
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   synchronous reset, active-low
//   op         in   opcode IR[31:26], valid from ID onward
//   zero       in   ALU zero flag, valid in EXE
//   mem_ready  in   data-memory ready (MEM_WAIT_EN only)
//   PCWre, IRWre, InsMemRW, RegWre, mRD, mWR        strobes
//   ALUSrcA, ALUSrcB, ALUOp, ExtSel                  ALU selects
//   RegDst, WrRegDSrc, DBDataSrc, PCSrc              datapath mux selects
//   state      out  current state (debug)
//   halted     out  core stopped
module mc_ctrl_fsm #(
  parameter int OPW = 6,
  parameter logic [OPW-1:0] HALT_OP = 6'b111111
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [OPW-1:0] op,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           PCWre,
  output logic           IRWre,
  output logic           InsMemRW,
  output logic           ALUSrcA,
  output logic           ALUSrcB,
  output logic [2:0]     ALUOp,
  output logic           ExtSel,
  output logic [1:0]     RegDst,
  output logic           RegWre,
  output logic           WrRegDSrc,
  output logic           DBDataSrc,
  output logic           mRD,
  output logic           mWR,
  output logic [1:0]     PCSrc,
  output logic [2:0]     state,
  output logic           halted
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  localparam logic [OPW-1:0] OP_ADD   = 6'b000000;
  localparam logic [OPW-1:0] OP_SUB   = 6'b000001;
  localparam logic [OPW-1:0] OP_ADDIU = 6'b000010;
  localparam logic [OPW-1:0] OP_AND   = 6'b010000;
  localparam logic [OPW-1:0] OP_ANDI  = 6'b010001;
  localparam logic [OPW-1:0] OP_ORI   = 6'b010010;
  localparam logic [OPW-1:0] OP_SLL   = 6'b011000;
  localparam logic [OPW-1:0] OP_SLT   = 6'b100110;
  localparam logic [OPW-1:0] OP_SW    = 6'b110000;
  localparam logic [OPW-1:0] OP_LW    = 6'b110001;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b110100;
  localparam logic [OPW-1:0] OP_BNE   = 6'b110101;
  localparam logic [OPW-1:0] OP_J     = 6'b111000;
  localparam logic [OPW-1:0] OP_JR    = 6'b111001;
  localparam logic [OPW-1:0] OP_JAL   = 6'b111010;

  state_t state_q;

  logic is_rtype, is_imm, is_sw, is_lw, is_beq, is_bne, is_branch;
  logic is_j, is_jr, is_jal, is_jump, is_halt, writes_reg, take_branch;
  logic mem_ok;

  assign is_rtype   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                      (op == OP_SLL) || (op == OP_SLT);
  assign is_imm     = (op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_ORI);
  assign is_sw      = (op == OP_SW);
  assign is_lw      = (op == OP_LW);
  assign is_beq     = (op == OP_BEQ);
  assign is_bne     = (op == OP_BNE);
  assign is_branch  = is_beq || is_bne;
  assign is_j       = (op == OP_J);
  assign is_jr      = (op == OP_JR);
  assign is_jal     = (op == OP_JAL);
  assign is_jump    = is_j || is_jr || is_jal;
  assign is_halt    = (op == HALT_OP);
  // Unknown opcodes fall through EXE->WB as NOPs: no register write.
  assign writes_reg = is_rtype || is_imm || is_lw;
  assign take_branch = (is_beq && zero) || (is_bne && !zero);

`ifdef MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  assign state = state_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IF;
    end else begin
      case (state_q)
        S_IF:  state_q <= S_ID;
        S_ID: begin
          if (is_jump)      state_q <= S_IF;
          else if (is_halt) state_q <= S_HALT;
          else              state_q <= S_EXE;
        end
        S_EXE: begin
          if (is_branch)          state_q <= S_IF;
          else if (is_sw || is_lw) state_q <= S_MEM;
          else                    state_q <= S_WB;
        end
        S_MEM: begin
          if (!mem_ok)    state_q <= S_MEM;
          else if (is_lw) state_q <= S_WB;
          else            state_q <= S_IF;
        end
        S_WB:   state_q <= S_IF;
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_IF;
      endcase
    end
  end

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    RegWre    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PCSrc     = 2'b00;
    halted    = 1'b0;

    // Selects follow the opcode in every state so the datapath sees stable
    // values; only the strobes are state-qualified.
    ALUSrcA   = (op == OP_SLL);
    ALUSrcB   = is_imm || is_sw || is_lw;
    ExtSel    = (op == OP_ADDIU) || is_sw || is_lw || is_branch;
    WrRegDSrc = !is_jal;
    DBDataSrc = is_lw;

    if (is_jal)        RegDst = 2'b00;
    else if (is_rtype) RegDst = 2'b10;
    else               RegDst = 2'b01;

    if ((op == OP_SUB) || is_branch)              ALUOp = 3'b001;
    else if (op == OP_SLT)                        ALUOp = 3'b010;
    else if (op == OP_ORI)                        ALUOp = 3'b011;
    else if ((op == OP_AND) || (op == OP_ANDI))   ALUOp = 3'b100;
    else                                          ALUOp = 3'b000;

    case (state_q)
      S_IF: begin
        IRWre    = 1'b1;
        InsMemRW = 1'b1;
      end
      S_ID: begin
        if (is_jump) begin
          PCWre  = 1'b1;
          PCSrc  = is_jr ? 2'b10 : 2'b11;
          RegWre = is_jal;
        end
      end
      S_EXE: begin
        if (is_branch) begin
          PCWre = 1'b1;
          PCSrc = take_branch ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        mWR = is_sw;
        mRD = is_lw;
        // sw finishes here; with a waiting memory only on the ready cycle.
        PCWre = is_sw && mem_ok;
      end
      S_WB: begin
        RegWre = writes_reg;
        PCWre  = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase

    // Reset aborts the instruction: no architectural side effects.
    if (!RST) begin
      PCWre  = 1'b0;
      RegWre = 1'b0;
      mRD    = 1'b0;
      mWR    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - randomized self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

  localparam logic [2:0] P_IF = 3'd0, P_ID = 3'd1, P_EXE = 3'd2,
                         P_MEM = 3'd3, P_WB = 3'd4, P_HALT = 3'd7;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDIU = 6'b000010,
                         AND_ = 6'b010000, ANDI = 6'b010001, ORI = 6'b010010,
                         SLL = 6'b011000, SLT = 6'b100110, SW = 6'b110000,
                         LW = 6'b110001, BEQ = 6'b110100, BNE = 6'b110101,
                         J = 6'b111000, JR = 6'b111001, JAL = 6'b111010,
                         HALT = 6'b111111;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic [5:0] op = 6'd0;
  logic zero = 1'b0;
  logic mem_ready = 1'b1;
  logic PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, RegWre;
  logic WrRegDSrc, DBDataSrc, mRD, mWR, halted;
  logic [2:0] ALUOp, state;
  logic [1:0] RegDst, PCSrc;

  int checks = 0;
  int failures = 0;
  logic [2:0] plan[$];
  logic [5:0] op_table[15];

  mc_ctrl_fsm dut (
    .CLK(CLK), .RST(RST), .op(op), .zero(zero), .mem_ready(mem_ready),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel), .RegDst(RegDst),
    .RegWre(RegWre), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
    .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc), .state(state), .halted(halted)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t op=%b)", tag, got, exp, $time, op);
    end
  endtask

  function automatic bit is_rtype(input logic [5:0] o);
    return o == ADD || o == SUB || o == AND_ || o == SLL || o == SLT;
  endfunction

  function automatic bit is_imm(input logic [5:0] o);
    return o == ADDIU || o == ANDI || o == ORI;
  endfunction

  function automatic bit writes_reg(input logic [5:0] o);
    return is_rtype(o) || is_imm(o) || o == LW || o == JAL;
  endfunction

  function automatic bit is_known(input logic [5:0] o);
    foreach (op_table[i]) if (op_table[i] == o) return 1'b1;
    return o == HALT;
  endfunction

  // Phases an instruction visits, straight from its class.
  task automatic build_plan(input logic [5:0] o);
    plan.delete();
    plan.push_back(P_IF);
    plan.push_back(P_ID);
    if (o == J || o == JR || o == JAL) return;
    plan.push_back(P_EXE);
    if (o == BEQ || o == BNE) return;
    if (o == SW) begin plan.push_back(P_MEM); return; end
    if (o == LW) plan.push_back(P_MEM);
    plan.push_back(P_WB);
  endtask

  function automatic logic [1:0] exp_pcsrc(input logic [5:0] o, input logic z);
    if (o == J || o == JAL) return 2'b11;
    if (o == JR) return 2'b10;
    if ((o == BEQ && z) || (o == BNE && !z)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_cycle(input logic [5:0] o, input logic [2:0] p, input bit last);
    check("state", 32'(state), 32'(p));
    check("IRWre", 32'(IRWre), 32'(p == P_IF));
    check("InsMemRW", 32'(InsMemRW), 32'(p == P_IF));
    check("PCWre", 32'(PCWre), 32'(last));
    check("RegWre", 32'(RegWre), 32'(last && writes_reg(o)));
    check("mRD", 32'(mRD), 32'(p == P_MEM && o == LW));
    check("mWR", 32'(mWR), 32'(p == P_MEM && o == SW));
    check("halted", 32'(halted), 32'(0));
    if (last) check("PCSrc", 32'(PCSrc), 32'(exp_pcsrc(o, zero)));
    if (last && writes_reg(o)) begin
      check("RegDst", 32'(RegDst), 32'(o == JAL ? 2'b00 : is_rtype(o) ? 2'b10 : 2'b01));
      check("WrRegDSrc", 32'(WrRegDSrc), 32'(o != JAL));
      check("DBDataSrc", 32'(DBDataSrc), 32'(o == LW));
    end
    if (p == P_EXE) begin
      if (o == BEQ || o == BNE) check("ALUOp_br", 32'(ALUOp), 32'(3'b001));
      if (o == SW || o == LW) begin
        check("ALUOp_mem", 32'(ALUOp), 32'(3'b000));
        check("ALUSrcB_mem", 32'(ALUSrcB), 32'(1));
      end
      if (o == ANDI || o == ORI) check("ExtSel_zx", 32'(ExtSel), 32'(0));
      if (o == ADDIU || o == SW || o == LW || o == BEQ || o == BNE)
        check("ExtSel_sx", 32'(ExtSel), 32'(1));
      if (o == SUB) check("ALUOp_sub", 32'(ALUOp), 32'(3'b001));
      if (o == SLT) check("ALUOp_slt", 32'(ALUOp), 32'(3'b010));
      if (o == ORI) check("ALUOp_or", 32'(ALUOp), 32'(3'b011));
      if (o == AND_ || o == ANDI) check("ALUOp_and", 32'(ALUOp), 32'(3'b100));
      if (o == SLL) check("ALUSrcA_sll", 32'(ALUSrcA), 32'(1));
    end
  endtask

  // Entered and left at posedge+1 of an IF cycle.
  // zsel: 0/1 fixed zero, 2 random. waits: forced MEM wait count, -1 random.
  task automatic run_instr(input logic [5:0] o, input int zsel, input int waits);
    int nwait;
    bit last, hold;
    build_plan(o);
    op = o;
    nwait = 0;
    for (int k = 0; k < plan.size(); k++) begin
      zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      mem_ready = 1'($urandom_range(0, 1));
      hold = 1'b0;
`ifdef MEM_WAIT_EN
      if (plan[k] == P_MEM) begin
        if (waits >= 0) mem_ready = (nwait >= waits);
        else if (nwait >= 4) mem_ready = 1'b1;
      end
      hold = (plan[k] == P_MEM) && !mem_ready;
`else
      if (waits > 0) mem_ready = 1'b0;
`endif
      last = !hold && (k == plan.size() - 1);
      #1 check_cycle(o, plan[k], last);
      @(posedge CLK); #1;
      if (hold) begin
        nwait++;
        k--;
      end
    end
  endtask

  // Run an instruction up to phase index at_k, then reset in that cycle.
  task automatic abort_at(input logic [5:0] o, input int at_k);
    build_plan(o);
    op = o;
    zero = 1'b0;
    mem_ready = 1'b1;
    for (int k = 0; k < at_k; k++) begin
      #1 check_cycle(o, plan[k], 1'b0);
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    #1;
    check("abort_state", 32'(state), 32'(plan[at_k]));
    check("abort_PCWre", 32'(PCWre), 32'(0));
    check("abort_RegWre", 32'(RegWre), 32'(0));
    @(posedge CLK); #1;
    RST = 1'b1;
    check("abort_to_IF", 32'(state), 32'(P_IF));
  endtask

  initial begin
    logic [5:0] o;
    op_table = '{ADD, SUB, ADDIU, AND_, ANDI, ORI, SLL, SLT, SW, LW, BEQ, BNE, J, JR, JAL};

    RST = 1'b0;
    @(posedge CLK);
    @(posedge CLK); #1;
    check("reset_state", 32'(state), 32'(P_IF));
    check("reset_PCWre", 32'(PCWre), 32'(0));
    check("reset_RegWre", 32'(RegWre), 32'(0));
    RST = 1'b1;

    run_instr(ADD, 0, -1);
    run_instr(LW, 0, -1);
    run_instr(BEQ, 1, -1);
    run_instr(BEQ, 0, -1);
    run_instr(BNE, 0, -1);
    run_instr(BNE, 1, -1);
    run_instr(JAL, 0, -1);
    run_instr(JR, 0, -1);
    run_instr(6'b101010, 0, -1);
    run_instr(SW, 0, 3);
    run_instr(LW, 0, 2);

    for (int n = 0; n < 400; n++) begin
      int pick = int'($urandom_range(0, 17));
      if (pick < 15) begin
        o = op_table[pick];
      end else begin
        o = 6'($urandom);
        while (is_known(o)) o = 6'($urandom);
      end
      run_instr(o, 2, -1);
    end
    check("back_in_IF", 32'(state), 32'(P_IF));

    abort_at(ADD, 3);
    abort_at(SW, 3);
    abort_at(LW, 4);
    run_instr(ORI, 2, -1);

    op = HALT;
    zero = 1'b0;
    mem_ready = 1'b1;
    #1 check("halt_IF", 32'(state), 32'(P_IF));
    @(posedge CLK); #1;
    check("halt_ID", 32'(state), 32'(P_ID));
    check("halt_ID_PCWre", 32'(PCWre), 32'(0));
    @(posedge CLK); #1;
    for (int n = 0; n < 20; n++) begin
      op = 6'($urandom);
      #1;
      check("halt_state", 32'(state), 32'(P_HALT));
      check("halt_flag", 32'(halted), 32'(1));
      check("halt_PCWre", 32'(PCWre), 32'(0));
      check("halt_RegWre", 32'(RegWre), 32'(0));
      check("halt_IRWre", 32'(IRWre), 32'(0));
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    check("halt_reset_IF", 32'(state), 32'(P_IF));
    check("halt_reset_flag", 32'(halted), 32'(0));
    run_instr(SLT, 2, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
